move_ctrl: RTL and testbench
============================

Name: move_ctrl

Overview:
- Upstream stage of the playfield block.
- Turns four raw board buttons and a gravity timer into single-cycle, mutually exclusive move pulses (leftTrue, rightTrue, downTrue, rotateTrue).
- Supplies a pseudo-random blockType in range 0..4.
- Holds all game-logic inputs quiet while gameOver is high.

Parameters:
- DEBOUNCE_CYCLES, 250000: consecutive stable synchronized samples required before a button's debounced level changes. Minimum 1.
- GRAVITY_CYCLES, 25000000: period in clocks of the automatic down request. Minimum 4.
- HOLDOFF_CYCLES, 2: idle cycles forced after any issued pulse, so the playfield can finish a next-block load.

Ports:
- clock  in  1  system clock
- resetn  in  1  reset
- btnLeft  in  1  raw asynchronous button, high = pressed
- btnRight  in  1  raw asynchronous button, high = pressed
- btnDown  in  1  raw asynchronous button, high = pressed
- btnRotate  in  1  raw asynchronous button, high = pressed
- gameOver  in  1  playfield game-over flag, level
- leftTrue  out  1  one-cycle move-left pulse
- rightTrue  out  1  one-cycle move-right pulse
- downTrue  out  1  one-cycle move-down pulse
- rotateTrue  out  1  one-cycle rotate pulse
- blockType  out  3  next shape index, always 0..4

Interface constraint: one clock; reset is asynchronous and active-low (ports clock, resetn).

Behaviour:
- Reset: all pulse outputs 0; all pending flags 0; gravity counter 0; debounced levels 0; state IDLE; LFSR 8'h01; blockType 3'd1.
- Synchronizer: each button passes through a 2-flop synchronizer.
- Debounce:
  - Per-button counter increments while the synchronized level differs from the debounced level, and clears when they agree.
  - When the counter reaches DEBOUNCE_CYCLES, the debounced level flips and the counter clears.
- Pending flags:
  - A rising edge of a debounced level sets that button's pending flag.
  - Falling edges are ignored.
- Gravity:
  - Counter runs 0..GRAVITY_CYCLES-1 and wraps.
  - On wrap it sets the down-pending flag.
  - Issuing any downTrue (manual or gravity) clears the counter to 0 in the same cycle.
- Arbiter FSM, states IDLE, HOLD, OVER:
  - IDLE: if any flag is pending, issue exactly one registered pulse, clear that flag, load the hold counter with HOLDOFF_CYCLES, and go to HOLD.
  - Priority order: down > left > right > rotate.
  - HOLD: all outputs 0; decrement the hold counter; return to IDLE at 0. Pending flags continue to collect.
  - Any state to OVER when gameOver=1: outputs forced 0 in the same registered cycle; pending flags cleared; gravity counter held at 0.
  - OVER to IDLE when gameOver=0. Button edges during OVER are discarded.
- Latency: a clean raw rising edge produces its pulse DEBOUNCE_CYCLES+4 clocks later, provided the FSM is IDLE and nothing of higher priority is pending.
- Pulses never overlap, and pulses are separated by at least HOLDOFF_CYCLES zero cycles.
- Simultaneous presses: each press is issued once, in priority order, with HOLDOFF spacing between them.
- A repeated press of an already-pending button collapses into a single pulse.
- blockType:
  - LFSR is Galois, taps x^8+x^6+x^5+x^4+1, and advances every cycle including during OVER.
  - blockType = lfsr[2:0] when < 5, otherwise lfsr[2:0]-5. Registered.
- Asynchronous reset mid-hold or mid-debounce returns every register to its reset value immediately.

Optional Feature:
- AUTO_REPEAT_EN defined: while debounced left or right stays high, re-arm its pending flag 16×HOLDOFF_CYCLES+DEBOUNCE_CYCLES clocks after the first issue, then every 8×HOLDOFF_CYCLES clocks until release. Release stops repeats immediately.
- Undefined: exactly one pulse per press; no repeat counters are synthesized.

Decomposition:
- Package tetris_pkg:
  - NUM_SHAPES=5.
  - Shape index constants SHAPE_I..SHAPE_Z (0..4).
  - FSM state encoding for IDLE/HOLD/OVER.
  - LFSR_SEED=8'h01 and the tap mask.
- Sub-module btn_debounce (synchronizer, debounce counter, rising-edge output), instantiated four times.

Test Plan:
- DEBOUNCE_CYCLES=4, GRAVITY_CYCLES=1000: btnLeft high for 20 cycles -> leftTrue is a single 1-cycle pulse exactly 8 clocks after the first sampled high; no other outputs toggle.
- btnRight glitch high for 3 cycles, then low -> no rightTrue ever.
- btnDown, btnLeft and btnRotate rise in the same cycle (HOLDOFF=2) -> downTrue at t, leftTrue at t+3, rotateTrue at t+6; gravity counter reads 0 at t+1.
- No buttons, GRAVITY_CYCLES=10 -> downTrue every 13 clocks steady-state (10-cycle period plus 1 pulse and 2 hold cycles are not overlapped because the counter restarts on issue); verify interval is constant.
- gameOver=1 while btnLeft is pending -> no pulses for 500 cycles, gravity counter stays 0; gameOver=0 -> still no leftTrue (flag discarded).
- Over 1000 cycles, blockType stays within 0..4; first three values after reset match the LFSR model (1, 2, 4).

Source files
------------

// File: rtl/tetris_pkg.sv
// tetris_pkg: shared shape indices, arbiter state encoding and LFSR helpers for move_ctrl.
package tetris_pkg;
  localparam int NUM_SHAPES = 5;
  localparam logic [2:0] SHAPE_I = 3'd0, SHAPE_O = 3'd1, SHAPE_T = 3'd2, SHAPE_S = 3'd3, SHAPE_Z = 3'd4;
  typedef enum logic [1:0] {IDLE = 2'd0, HOLD = 2'd1, OVER = 2'd2} state_t;
  localparam logic [7:0] LFSR_SEED = 8'h01;
  localparam logic [7:0] LFSR_TAPS = 8'h71;
  // Galois step for x^8+x^6+x^5+x^4+1, shifting toward the MSB
  function automatic logic [7:0] lfsr_step(input logic [7:0] l);
    return {l[6:0], 1'b0} ^ (l[7] ? LFSR_TAPS : 8'h00);
  endfunction
  function automatic logic [2:0] shape_of(input logic [7:0] l);
    return l[2:0] > SHAPE_Z ? l[2:0] - 3'(NUM_SHAPES) : l[2:0];
  endfunction
endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: 2-flop synchronizer, stability counter and registered rising-edge pulse.
// AUTO_REPEAT_EN exposes the debounced level for the repeat timers.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic clock,
  input  logic resetn,
  input  logic raw,
`ifdef AUTO_REPEAT_EN
  output logic level,
`endif
  output logic rise
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  logic [1:0] sync;
  logic [CW-1:0] cnt;
  logic lvl, hit;
  assign hit = sync[1] != lvl && cnt == CW'(DEBOUNCE_CYCLES);
`ifdef AUTO_REPEAT_EN
  assign level = lvl;
`endif
  always_ff @(posedge clock or negedge resetn)
    if (!resetn) begin
      sync <= 2'b00;
      cnt  <= '0;
      lvl  <= 1'b0;
      rise <= 1'b0;
    end else begin
      sync <= {sync[0], raw};
      cnt  <= (sync[1] == lvl || hit) ? '0 : cnt + 1'b1;
      lvl  <= lvl ^ hit;
      rise <= hit && !lvl;
    end
endmodule

// File: rtl/move_ctrl.sv
// move_ctrl: debounced buttons and gravity timer arbitrated into exclusive one-cycle move pulses, plus blockType.
// Optional AUTO_REPEAT_EN re-arms left/right while they stay held.
module move_ctrl #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int GRAVITY_CYCLES = 25000000,
  parameter int HOLDOFF_CYCLES = 2
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       btnLeft,
  input  logic       btnRight,
  input  logic       btnDown,
  input  logic       btnRotate,
  input  logic       gameOver,
  output logic       leftTrue,
  output logic       rightTrue,
  output logic       downTrue,
  output logic       rotateTrue,
  output logic [2:0] blockType
);
  import tetris_pkg::*;
  localparam int GW = $clog2(GRAVITY_CYCLES);
  localparam int HW = $clog2(HOLDOFF_CYCLES + 2);
  logic [3:0] raw, rise, pend, sel, set;
  logic gwrap;
  state_t state, state_nx;
  logic [HW-1:0] hold;
  logic [GW-1:0] grav;
  logic [7:0] lfsr, lfsr_nx;
  assign raw = {btnRotate, btnRight, btnLeft, btnDown};
`ifdef AUTO_REPEAT_EN
  localparam int FIRST = 16 * HOLDOFF_CYCLES + DEBOUNCE_CYCLES;
  localparam int NEXT = 8 * HOLDOFF_CYCLES;
  localparam int RW = $clog2(FIRST + 1);
  logic [3:0] lvl;
  logic [2:1] rep;
  for (genvar r = 1; r < 3; r++) begin : g_rep
    logic first;
    logic [RW-1:0] cnt;
    assign rep[r] = lvl[r] && cnt == RW'((first ? FIRST : NEXT) - 1);
    always_ff @(posedge clock or negedge resetn)
      if (!resetn) begin
        first <= 1'b1;
        cnt   <= '0;
      end else if (!lvl[r]) begin
        first <= 1'b1;
        cnt   <= '0;
      end else if (sel[r]) cnt <= '0;
      else if (rep[r]) begin
        first <= 1'b0;
        cnt   <= '0;
      end else cnt <= cnt + 1'b1;
  end
  assign set = {rise[3], rise[2:1] | rep, rise[0] | gwrap};
`else
  assign set = {rise[3:1], rise[0] | gwrap};
`endif
  for (genvar i = 0; i < 4; i++) begin : g_btn
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clock(clock),
      .resetn(resetn),
      .raw(raw[i]),
`ifdef AUTO_REPEAT_EN
      .level(lvl[i]),
`endif
      .rise(rise[i])
    );
  end
  always_ff @(posedge clock or negedge resetn)
    if (!resetn) state <= IDLE;
    else state <= state_nx;
  always_comb
    state_nx = gameOver ? OVER :
               state == IDLE ? (|pend ? HOLD : IDLE) :
               state == HOLD ? (hold <= HW'(1) ? IDLE : HOLD) : IDLE;
  // lowest set bit wins: down > left > right > rotate
  always_comb sel = (state == IDLE && !gameOver) ? pend & (~pend + 4'd1) : 4'd0;
  assign gwrap = state == IDLE && !gameOver && !sel[0] && grav == GW'(GRAVITY_CYCLES - 1);
  assign lfsr_nx = lfsr_step(lfsr);
  // gravity pauses through the holdoff, so its period restarts once the hold ends
  always_ff @(posedge clock or negedge resetn)
    if (!resetn) begin
      hold <= '0;
      pend <= 4'd0;
      grav <= '0;
      {rotateTrue, rightTrue, leftTrue, downTrue} <= 4'd0;
      lfsr <= LFSR_SEED;
      blockType <= SHAPE_O;
    end else begin
      hold <= |sel ? HW'(HOLDOFF_CYCLES) : state == HOLD ? hold - 1'b1 : hold;
      pend <= (gameOver || state == OVER) ? 4'd0 : (pend & ~sel) | set;
      grav <= (gameOver || state == OVER || sel[0]) ? '0 : state != IDLE ? grav : gwrap ? '0 : grav + 1'b1;
      {rotateTrue, rightTrue, leftTrue, downTrue} <= sel;
      lfsr <= lfsr_nx;
      blockType <= shape_of(lfsr_nx);
    end
endmodule

// File: tb/tb_move_ctrl.sv
// tb_move_ctrl: table vectors, corner sequences and random stimulus checked against a behavioural model.
module tb_move_ctrl;
  localparam int D = 4, G = 1000, H = 2, GG = 10;
  logic clock = 1'b0, resetn = 1'b0, go = 1'b0;
  logic [3:0] btn = 4'd0;
  logic lt, rt, dt, rot, glt, grt, gdt, grot;
  logic [2:0] bt, gbt;
  logic [3:0] outs;
  assign outs = {rot, rt, lt, dt};
  always #5 clock = ~clock;

  move_ctrl #(.DEBOUNCE_CYCLES(D), .GRAVITY_CYCLES(G), .HOLDOFF_CYCLES(H)) dut (
    .clock(clock), .resetn(resetn), .btnLeft(btn[1]), .btnRight(btn[2]), .btnDown(btn[0]),
    .btnRotate(btn[3]), .gameOver(go), .leftTrue(lt), .rightTrue(rt), .downTrue(dt),
    .rotateTrue(rot), .blockType(bt));
  move_ctrl #(.DEBOUNCE_CYCLES(D), .GRAVITY_CYCLES(GG), .HOLDOFF_CYCLES(H)) dut_g (
    .clock(clock), .resetn(resetn), .btnLeft(1'b0), .btnRight(1'b0), .btnDown(1'b0),
    .btnRotate(1'b0), .gameOver(1'b0), .leftTrue(glt), .rightTrue(grt), .downTrue(gdt),
    .rotateTrue(grot), .blockType(gbt));

  int total = 0, bad = 0, cyc = 0, start = 0;
  int ev_t[$], ev_o[$], gev[$];
  int m_r1[4], m_r2[4], m_lvl[4], m_run[4], m_rq[4];
  int m_pend, m_wait, m_over, m_grav, m_l, m_bt, m_out;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_r1[i] = 0; m_r2[i] = 0; m_lvl[i] = 0; m_run[i] = 0; m_rq[i] = 0;
    end
    m_pend = 0; m_wait = 0; m_over = 0; m_grav = 0; m_l = 1; m_bt = 1; m_out = 0;
  endtask

  // one clock edge of the specified behaviour, from the values held before the edge
  task automatic model_edge();
    int rq, p, g, o;
    rq = 0; o = 0; p = m_pend; g = m_grav;
    for (int i = 0; i < 4; i++) rq |= m_rq[i] << i;
    if (go) begin p = 0; g = 0; m_over = 1; m_wait = 0; end
    else if (m_over != 0) begin p = 0; g = 0; m_over = 0; end
    else if (m_wait > 0) begin m_wait--; p |= rq; end
    else begin
      for (int b = 0; b < 4; b++) if (o == 0 && p[b]) o = 1 << b;
      p &= ~o;
      if (o == 1) g = 0;
      else if (g == G - 1) begin g = 0; p |= 1; end
      else g++;
      if (o != 0) m_wait = H;
      p |= rq;
    end
    for (int i = 0; i < 4; i++) begin
      if (m_r2[i] != m_lvl[i]) m_run[i]++; else m_run[i] = 0;
      m_rq[i] = 0;
      if (m_run[i] > D) begin
        m_rq[i] = int'(m_lvl[i] == 0);
        m_lvl[i] ^= 1;
        m_run[i] = 0;
      end
      m_r2[i] = m_r1[i];
      m_r1[i] = int'(btn[i]);
    end
    m_l = ((m_l << 1) & 255) ^ ((m_l & 128) != 0 ? 'h71 : 0);
    m_bt = (m_l % 8) < 5 ? m_l % 8 : m_l % 8 - 5;
    m_pend = p; m_grav = g; m_out = o;
  endtask

  task automatic tick(input logic [3:0] b, input logic g);
    btn = b; go = g;
    @(posedge clock);
    cyc++;
    model_edge();
    #1;
    chk("pulse", int'(outs), m_out);
    chk("block_type", int'(bt), m_bt);
    chk("bt_range", int'(bt <= 3'd4), 1);
    chk("gravity_cnt", int'(dut.grav), m_grav);
    if (outs != 4'd0) begin ev_t.push_back(cyc - start); ev_o.push_back(int'(outs)); end
    if (gdt) gev.push_back(cyc - start);
  endtask

  task automatic clear_log();
    ev_t.delete(); ev_o.delete(); gev.delete();
    start = cyc + 1;
  endtask

  task automatic do_reset();
    resetn = 1'b0; btn = 4'd0; go = 1'b0;
    model_reset();
    @(posedge clock);
    #1;
    chk("reset_pulse", int'(outs), 0);
    chk("reset_bt", int'(bt), 1);
    chk("reset_grav", int'(dut.grav), 0);
    resetn = 1'b1;
    clear_log();
  endtask

  task automatic run(input logic [3:0] b, input int len, input int n);
    for (int k = 0; k < n; k++) tick(k < len ? b : 4'd0, 1'b0);
  endtask

  typedef struct {
    logic [3:0] b;
    int len;
    int exp;
    int at;
  } vec_t;
  vec_t tv[7];

  initial begin
    logic [3:0] rb;
    logic rg;
    tv[0] = '{4'b0010, 20, 2, 8};
    tv[1] = '{4'b0100, 3, 0, 0};
    tv[2] = '{4'b0100, 4, 0, 0};
    tv[3] = '{4'b0100, 5, 4, 8};
    tv[4] = '{4'b1000, 12, 8, 8};
    tv[5] = '{4'b0001, 6, 1, 8};
    tv[6] = '{4'b0000, 10, 0, 0};
    model_reset();

    do_reset();
    tick(4'd0, 1'b0);
    chk("bt_seq_2", int'(bt), 2);
    tick(4'd0, 1'b0);
    chk("bt_seq_3", int'(bt), 4);

    for (int i = 0; i < 7; i++) begin
      do_reset();
      run(tv[i].b, tv[i].len, 40);
      chk("event_count", ev_t.size(), int'(tv[i].exp != 0));
      if (tv[i].exp != 0 && ev_t.size() > 0) begin
        chk("event_kind", ev_o[0], tv[i].exp);
        chk("event_time", ev_t[0], tv[i].at);
      end
    end

    do_reset();
    run(4'b1011, 10, 30);
    chk("simul_count", ev_t.size(), 3);
    if (ev_t.size() == 3) begin
      chk("simul_down", ev_o[0], 1); chk("simul_down_t", ev_t[0], 8);
      chk("simul_left", ev_o[1], 2); chk("simul_left_t", ev_t[1], 11);
      chk("simul_rot", ev_o[2], 8); chk("simul_rot_t", ev_t[2], 14);
    end

    do_reset();
    run(4'b0011, 9, 9);
    for (int k = 0; k < 500; k++) tick(4'd0, 1'b1);
    chk("over_grav", int'(dut.grav), 0);
    run(4'd0, 0, 40);
    chk("over_count", ev_t.size(), 1);
    if (ev_t.size() == 1) chk("over_first", ev_o[0], 1);

    do_reset();
    run(4'b0001, 9, 9);
    #2;
    resetn = 1'b0;
    #1;
    chk("async_pulse", int'(outs), 0);
    chk("async_bt", int'(bt), 1);
    chk("async_grav", int'(dut.grav), 0);
    model_reset();
    @(negedge clock);
    resetn = 1'b1;
    clear_log();
    run(4'b0001, 10, 30);
    chk("after_async_count", ev_t.size(), 1);
    if (ev_t.size() == 1) chk("after_async_t", ev_t[0], 8);

    do_reset();
    run(4'd0, 0, 80);
    chk("grav_count", gev.size(), 6);
    for (int k = 0; k < gev.size() && k < 6; k++) chk("grav_time", gev[k], 10 + 13 * k);

    do_reset();
    rb = 4'd0; rg = 1'b0;
    for (int n = 0; n < 4000; n++) begin
      for (int i = 0; i < 4; i++) if ($urandom_range(0, 9) == 0) rb[i] = ~rb[i];
      if (rg) rg = $urandom_range(0, 19) != 0;
      else rg = $urandom_range(0, 399) == 0;
      tick(rb, rg);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
